// File: rtl/eth_clk_pkg.sv
// Shared Ethernet clocking types: the 2-bit link speed code used by both the
// TX clock divider setting and the RX clock speed detector.
package eth_clk_pkg;

  localparam int SPEED_W = 2;

  typedef enum logic [SPEED_W-1:0] {
    SPEED_1000 = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_10   = 2'b10,
    SPEED_NONE = 2'b11
  } speed_e;

endpackage

// File: rtl/rx_clk_period_counter.sv
// Measures RX clock period in clk250 cycles from a toggle bit and classifies it.
// Optional input synchronizer enabled by RX_CLK_SPEED_DET_SYNC_EN.
module rx_clk_period_counter
  import eth_clk_pkg::*;
#(
  parameter int timeout_p     = 1023,
  parameter int thresh_1000_p = 4,
  parameter int thresh_100_p  = 40
) (
  input  logic       clk250_i,
  input  logic       clk250_rst_i,
  input  logic       rx_clk_toggle_i,
  output logic       meas_v_o,
  output logic [1:0] meas_speed_o
);

  localparam int W = $clog2(timeout_p + 1);
  localparam logic [W-1:0] LP_TIMEOUT = W'(timeout_p);
  localparam logic [W:0]   LP_T1000   = (W + 1)'(thresh_1000_p);
  localparam logic [W:0]   LP_T100    = (W + 1)'(thresh_100_p);

  logic         w_tog_in;
  logic         r_tog;
  logic         r_tog_prev;
  logic         r_armed;
  logic [W-1:0] r_cnt;
  logic         w_edge;
  logic         w_timeout;
  logic [W:0]   w_period;

`ifdef RX_CLK_SPEED_DET_SYNC_EN
  // Two-flop synchronizer (bsg_sync_sync equivalent) ahead of the edge register.
  logic [1:0] r_sync;
  always_ff @(posedge clk250_i) begin
    if (clk250_rst_i) r_sync <= '0;
    else              r_sync <= {r_sync[0], rx_clk_toggle_i};
  end
  assign w_tog_in = r_sync[1];
`else
  assign w_tog_in = rx_clk_toggle_i;
`endif

  assign w_edge    = r_tog ^ r_tog_prev;
  assign w_timeout = !w_edge && (r_cnt == LP_TIMEOUT);
  assign w_period  = {1'b0, r_cnt} + (W + 1)'(1);

  always_ff @(posedge clk250_i) begin
    if (clk250_rst_i) begin
      r_tog      <= 1'b0;
      r_tog_prev <= 1'b0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_tog      <= w_tog_in;
      r_tog_prev <= r_tog;
      if (w_edge || w_timeout)     r_cnt <= '0;
      else if (r_cnt != LP_TIMEOUT) r_cnt <= r_cnt + W'(1);
      if (w_edge)         r_armed <= 1'b1;
      else if (w_timeout) r_armed <= 1'b0;
    end
  end

  // The arming edge has no valid start point, so it yields no measurement.
  always_comb begin
    meas_v_o     = 1'b0;
    meas_speed_o = SPEED_NONE;
    if (w_edge) begin
      if (r_armed) begin
        meas_v_o = 1'b1;
        if (w_period <= LP_T1000)     meas_speed_o = SPEED_1000;
        else if (w_period <= LP_T100) meas_speed_o = SPEED_100;
        else                          meas_speed_o = SPEED_10;
      end
    end else if (w_timeout) begin
      meas_v_o     = 1'b1;
      meas_speed_o = SPEED_NONE;
    end
  end

endmodule

// File: rtl/rx_clk_speed_detector.sv
// RGMII RX clock speed detector: period measurement plus hysteresis on the result.
// Build option RX_CLK_SPEED_DET_SYNC_EN adds a 2-flop input synchronizer.
module rx_clk_speed_detector
  import eth_clk_pkg::*;
#(
  parameter int timeout_p      = 1023,
  parameter int stable_count_p = 4,
  parameter int thresh_1000_p  = 4,
  parameter int thresh_100_p   = 40
) (
  input  logic       clk250_i,
  input  logic       clk250_rst_i,
  input  logic       rx_clk_toggle_i,
  output logic [1:0] speed_o,
  output logic       speed_v_o,
  output logic       speed_change_o
);

  localparam int MW = $clog2(stable_count_p + 1);
  localparam logic [MW-1:0] LP_STABLE = MW'(stable_count_p);

  logic          w_meas_v;
  logic [1:0]    w_meas_speed;
  logic [1:0]    r_cand;
  logic [MW-1:0] r_match;
  logic [1:0]    w_cand_nxt;
  logic [MW-1:0] w_match_nxt;
  logic [1:0]    r_speed;
  logic          r_speed_v;
  logic          r_change;

  rx_clk_period_counter #(
    .timeout_p     (timeout_p),
    .thresh_1000_p (thresh_1000_p),
    .thresh_100_p  (thresh_100_p)
  ) u_period (
    .clk250_i        (clk250_i),
    .clk250_rst_i    (clk250_rst_i),
    .rx_clk_toggle_i (rx_clk_toggle_i),
    .meas_v_o        (w_meas_v),
    .meas_speed_o    (w_meas_speed)
  );

  always_comb begin
    w_cand_nxt  = r_cand;
    w_match_nxt = r_match;
    if (w_meas_v) begin
      if (w_meas_speed == r_cand) begin
        if (r_match != LP_STABLE) w_match_nxt = r_match + MW'(1);
      end else begin
        w_cand_nxt  = w_meas_speed;
        w_match_nxt = MW'(1);
      end
    end
  end

  // Output follows the post-measurement candidate so it lands one cycle after the edge.
  always_ff @(posedge clk250_i) begin
    if (clk250_rst_i) begin
      r_cand    <= SPEED_NONE;
      r_match   <= '0;
      r_speed   <= SPEED_NONE;
      r_speed_v <= 1'b0;
      r_change  <= 1'b0;
    end else begin
      r_cand   <= w_cand_nxt;
      r_match  <= w_match_nxt;
      r_change <= 1'b0;
      if (w_meas_v && (w_match_nxt == LP_STABLE) && (w_cand_nxt != r_speed)) begin
        r_speed   <= w_cand_nxt;
        r_speed_v <= (w_cand_nxt != SPEED_NONE);
        r_change  <= 1'b1;
      end
    end
  end

  assign speed_o        = r_speed;
  assign speed_v_o      = r_speed_v;
  assign speed_change_o = r_change;

endmodule

// File: tb/tb_rx_clk_speed_detector.sv
// Self-checking bench for rx_clk_speed_detector: timestamp-based reference model,
// table-driven toggle segments, hand-written timeout/relock/reset sequences, random segments.
module tb_rx_clk_speed_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tog = 1'b0;
  logic [1:0] speed_o;
  logic       speed_v_o;
  logic       speed_change_o;

  always #2 clk = ~clk;

  rx_clk_speed_detector dut (
    .clk250_i        (clk),
    .clk250_rst_i    (rst),
    .rx_clk_toggle_i (tog),
    .speed_o         (speed_o),
    .speed_v_o       (speed_v_o),
    .speed_change_o  (speed_change_o)
  );

  localparam int TIMEOUT = 1023;
  localparam int STABLE  = 4;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_pulse = 0;

  // Reference model: periods are differences of event timestamps.
  logic       m_seen, m_edge, m_armed;
  int         m_ref;
  logic [1:0] m_cand, m_speed;
  int         m_match;
  logic       m_v, m_chg;

  function automatic logic [1:0] classify(int period);
    if (period <= 4)       return 2'b00;
    else if (period <= 40) return 2'b01;
    else                   return 2'b10;
  endfunction

  task automatic model_step();
    logic       mv;
    logic [1:0] m;
    if (rst) begin
      m_seen = 1'b0; m_edge = 1'b0; m_armed = 1'b0; m_ref = cyc;
      m_cand = 2'b11; m_match = 0; m_speed = 2'b11; m_v = 1'b0; m_chg = 1'b0;
    end else begin
      mv = 1'b0; m = 2'b11;
      if (m_edge) begin
        if (m_armed) begin mv = 1'b1; m = classify(cyc - m_ref); end
        m_armed = 1'b1; m_ref = cyc;
      end else if (cyc - m_ref == TIMEOUT + 1) begin
        mv = 1'b1; m = 2'b11; m_armed = 1'b0; m_ref = cyc;
      end
      m_chg = 1'b0;
      if (mv) begin
        if (m == m_cand) m_match = (m_match + 1 > STABLE) ? STABLE : m_match + 1;
        else begin m_cand = m; m_match = 1; end
        if (m_match == STABLE && m_cand != m_speed) begin
          m_speed = m_cand; m_v = (m_cand != 2'b11); m_chg = 1'b1;
        end
      end
      m_edge = (tog != m_seen);
      m_seen = tog;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (speed_change_o) n_pulse++;
    chk("speed", 32'(speed_o), 32'(m_speed));
    chk("speed_v", 32'(speed_v_o), 32'(m_v));
    chk("change", 32'(speed_change_o), 32'(m_chg));
  endtask

  task automatic apply_seg(int p, int alt, int n);
    for (int i = 0; i < n; i++) begin
      repeat (((i % 2) == 1) ? p + alt : p) tick();
      tog = ~tog;
    end
  endtask

  task automatic relock(output int lat);
    int t0;
    lat = -1;
    t0  = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (2) begin
        tick();
        if (speed_change_o && lat < 0 && i > 0) lat = cyc - t0;
      end
      tog = ~tog;
      if (i == 0) t0 = cyc;
    end
  endtask

  typedef struct {
    int         p;
    int         alt;
    int         n;
    logic [1:0] exp_speed;
    int         exp_pulses;
  } vec_t;

  vec_t tbl[5];
  int   lat;
  int   pulses0;

  initial begin
    tbl[0] = '{p: 10, alt: 0, n: 8,  exp_speed: 2'b01, exp_pulses: 1};
    tbl[1] = '{p: 9,  alt: 2, n: 10, exp_speed: 2'b01, exp_pulses: 0};
    tbl[2] = '{p: 100,alt: 0, n: 8,  exp_speed: 2'b10, exp_pulses: 1};
    tbl[3] = '{p: 4,  alt: 1, n: 12, exp_speed: 2'b10, exp_pulses: 0};
    tbl[4] = '{p: 2,  alt: 0, n: 12, exp_speed: 2'b00, exp_pulses: 1};

    rst = 1'b1; tog = 1'b0;
    repeat (2) tick();
    chk("reset_speed", 32'(speed_o), 32'd3);
    chk("reset_v", 32'(speed_v_o), 32'd0);
    chk("reset_change", 32'(speed_change_o), 32'd0);
    rst = 1'b0;

    pulses0 = n_pulse;
    relock(lat);
    chk("fresh_lock_latency", 32'(lat), 32'd10);
    chk("fresh_lock_speed", 32'(speed_o), 32'd0);
    chk("fresh_lock_v", 32'(speed_v_o), 32'd1);
    chk("fresh_lock_pulses", 32'(n_pulse - pulses0), 32'd1);

    pulses0 = n_pulse;
    repeat (4097) tick();
    chk("hold_before_timeout4", 32'(speed_o), 32'd0);
    tick();
    chk("hold_speed", 32'(speed_o), 32'd3);
    chk("hold_v", 32'(speed_v_o), 32'd0);
    chk("hold_change", 32'(speed_change_o), 32'd1);
    repeat (20) tick();
    chk("hold_pulses", 32'(n_pulse - pulses0), 32'd1);

    relock(lat);
    chk("relock_latency", 32'(lat), 32'd10);

    for (int i = 0; i < 5; i++) begin
      pulses0 = n_pulse;
      apply_seg(tbl[i].p, tbl[i].alt, tbl[i].n);
      repeat (3) tick();
      chk($sformatf("tbl%0d_speed", i), 32'(speed_o), 32'(tbl[i].exp_speed));
      chk($sformatf("tbl%0d_pulses", i), 32'(n_pulse - pulses0), 32'(tbl[i].exp_pulses));
    end

    tog = 1'b1;
    rst = 1'b1;
    tick();
    chk("midreset_speed", 32'(speed_o), 32'd3);
    chk("midreset_v", 32'(speed_v_o), 32'd0);
    chk("midreset_change", 32'(speed_change_o), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    for (int s = 0; s < 30; s++) begin
      int cls, p, alt, n;
      cls = int'($urandom_range(0, 4));
      alt = int'($urandom_range(0, 2));
      n   = int'($urandom_range(3, 8));
      case (cls)
        0:       p = int'($urandom_range(1, 6));
        1:       p = int'($urandom_range(6, 42));
        2:       p = int'($urandom_range(38, 120));
        3:       p = int'($urandom_range(3, 12));
        default: begin p = int'($urandom_range(1022, 1025)); n = 2; alt = 0; end
      endcase
      apply_seg(p, alt, n);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
    end
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
